// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide controller for the E stage.
// Owns HI/LO and models the fixed multi-cycle latency of MULT/DIV with a
// 4-bit busy counter. The result is computed and parked in pending_hi/lo
// when the operation starts. It is committed to HI/LO when the counter
// expires.
//
// Handshake: this block has no ready signal. An op is accepted when start=1
// and the unit is idle. While busy=1 a new start is ignored entirely. The
// hazard unit sees md_stall and holds the D-stage MD instruction until
// busy drops.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        state_dbg
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_we;

  logic        is_md_op;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;
  logic [3:0]  res_cycles;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] uq;
  logic [31:0] ur;

  assign is_md_op  = start && (op >= OP_MULT) && (op <= OP_DIVU);
  assign state_dbg = (state == RUN);

  // Stall D whenever an MD instruction there would collide with a running or
  // just-starting operation. Forced low while reset is held.
  assign md_stall = !reset && d_uses_md && (busy || is_md_op);

  // Arithmetic for the op presented this cycle. Signed division works on
  // magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  always_comb begin
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    a_neg      = A[31];
    b_neg      = B[31];
    a_mag      = a_neg ? (32'd0 - A) : A;
    b_mag      = b_neg ? (32'd0 - B) : B;
    sq_mag     = (B == 32'd0) ? 32'd0 : (a_mag / b_mag);
    sr_mag     = (B == 32'd0) ? 32'd0 : (a_mag % b_mag);
    uq         = (B == 32'd0) ? 32'd0 : (A / B);
    ur         = (B == 32'd0) ? 32'd0 : (A % B);
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_we     = 1'b0;
    res_cycles = 4'(MULT_CYCLES);
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      OP_DIV: begin
        res_lo     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
        res_hi     = a_neg ? (32'd0 - sr_mag) : sr_mag;
        res_we     = (B != 32'd0);
        res_cycles = 4'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_lo     = uq;
        res_hi     = ur;
        res_we     = (B != 32'd0);
        res_cycles = 4'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // IDLE/RUN control, busy counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md_op) begin
            pending_hi <= res_hi;
            pending_lo <= res_lo;
            pending_we <= res_we;
            cnt        <= res_cycles;
            busy       <= 1'b1;
            state      <= RUN;
          end else if (start && op == OP_MTHI) begin
            HI <= A;
          end else if (start && op == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            if (pending_we) begin
              HI <= pending_hi;
              LO <= pending_lo;
            end
            pending_we <= 1'b0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage pipeline; sits in the E stage next to the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and models the fixed multi-cycle latency with a busy counter.
- Owns the HI/LO registers and drives the extra stall request that the hazard unit ORs into stall_F/stall_D and reset_E.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  E-stage instruction is an MD-unit instruction; op valid this cycle
- op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- A  input  32  forwarded rs value from E
- B  input  32  forwarded rt value from E
- d_uses_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  output  1  multi-cycle operation in progress
- md_stall  output  1  stall request to hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port reset.
- Reset: HI=0, LO=0, busy=0, counter=0, pending results=0. Reset overrides start in the same cycle. Reset mid-operation aborts the operation, and its result is never written.
- States: IDLE (busy=0) and RUN (busy=1). The counter is 4 bits.
- IDLE with start=1 and op in 1..4 at edge T0:
  - Latch the computed result into pending_hi/pending_lo.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES) and go to RUN.
  - busy=1 during cycles T0+1 .. T0+N.
- RUN: counter decrements each edge. At the edge where counter==1, HI/LO <= pending values, busy <= 0, return to IDLE. New HI/LO and busy=0 are visible together from T0+N+1.
- MTHI/MTLO (op 5/6) with start=1 in IDLE: HI<=A or LO<=A at that edge (1-cycle); busy stays 0.
- start=1 while busy=1: ignored entirely. The hazard unit guarantees this cannot occur, and the bench checks that it has no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32 -> 64-bit; HI=upper 32 bits, LO=lower 32 bits.
  - DIV: signed; quotient truncates toward zero -> LO; remainder takes the sign of the dividend -> HI.
  - DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned; LO=A/B, HI=A%B.
  - Divide by zero (B=0): still busy for DIV_CYCLES; HI/LO left unchanged at completion.
- md_stall = d_uses_md & (busy | (start & op in 1..4)). This is combinational, has no registered delay, and is 0 during reset.
- HI/LO are read combinationally by mfhi/mflo in E. Writes from a completing operation and an MTHI/MTLO cannot coincide, because MTHI/MTLO cannot start while busy.

Test Plan:
- Reset then idle -> HI=0, LO=0, busy=0, md_stall=0 for 3 cycles.
- MULT A=0xFFFFFFFE B=3 at T0 -> busy=1 for T0+1..T0+5; at T0+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7) B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=2 -> LO=3, HI=1. DIV A=5 B=0 -> HI/LO unchanged, busy 10 cycles.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI and LO update one edge after each; busy stays 0.
- d_uses_md=1 with start=1 op=DIV in the same cycle -> md_stall=1 immediately and for all 10 busy cycles, 0 at T0+11. A second start during busy leaves HI/LO and the counter unaffected.
- Assert reset at T0+3 of a MULT -> busy=0 next cycle; HI=LO=0; the pending result is never written.
